// File: rtl/sysref_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysref_pkg
// Description : Shared definitions for the SYSREF alignment monitor: the
//               monitor state encoding and the default SYSREF timing
//               constants. The capture-side timing constraints and the
//               software register map use the same defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package sysref_pkg;

  // Monitor state, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } sysref_state_t;

  // Default SYSREF timing, in pl_clk cycles.
  localparam int c_default_exp_period = 64;
  localparam int c_default_tol        = 0;
  localparam int c_default_lock_count = 4;

endpackage
`default_nettype wire

// File: rtl/sysref_edge_period.sv
`default_nettype none
// ============================================================================
// Module      : sysref_edge_period
// Description : Rising-edge detector and edge-to-edge period counter for the
//               captured SYSREF level. Produces the combinational rise,
//               match and timeout flags used by the monitor FSM and holds
//               the last measured period.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   pl_clk        in   PL fabric clock
//   pl_resetn     in   asynchronous active-low reset
//   i_run         in   counter runs (monitor enabled and not IDLE)
//   i_meas_en     in   a rise updates o_period_meas (MEASURE / LOCKED)
//   i_sysref      in   captured SYSREF level, synchronous to pl_clk
//   o_rise        out  SYSREF rising edge this cycle
//   o_match       out  P = cnt+1 lies within EXP_PERIOD +/- TOL
//   o_timeout     out  cnt reached EXP_PERIOD+TOL without a rise
//   o_period_meas out  last measured period (CNT_W bits)
// ============================================================================
module sysref_edge_period #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 64,
  parameter int TOL        = 0
) (
  input  logic             pl_clk,
  input  logic             pl_resetn,
  input  logic             i_run,
  input  logic             i_meas_en,
  input  logic             i_sysref,
  output logic             o_rise,
  output logic             o_match,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_period_meas
);

  // Match window bounds; the lower bound clamps at zero for large TOL.
  localparam int               c_lo_int = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [CNT_W+1:0] c_lo     = (CNT_W+2)'(c_lo_int);
  localparam logic [CNT_W+1:0] c_hi     = (CNT_W+2)'(EXP_PERIOD + TOL);

  logic             r_sysref_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_meas;
  logic [CNT_W+1:0] w_period;
  logic [CNT_W-1:0] w_period_clip;

  assign o_rise = i_sysref & ~r_sysref_d;

  // P = cnt + 1 carried with two guard bits so neither the +1 nor the window
  // compare can wrap when cnt is saturated.
  assign w_period      = {2'b00, r_cnt} + (CNT_W+2)'(1);
  assign w_period_clip = (w_period[CNT_W+1:CNT_W] != 2'b00) ? '1 : w_period[CNT_W-1:0];

  assign o_match   = (w_period >= c_lo) && (w_period <= c_hi);
  assign o_timeout = ~o_rise && ({2'b00, r_cnt} >= c_hi);

  assign o_period_meas = r_period_meas;

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      r_sysref_d    <= 1'b0;
      r_cnt         <= '0;
      r_period_meas <= '0;
    end else begin
      r_sysref_d <= i_sysref;

      if (!i_run || o_rise) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (i_meas_en && o_rise) begin
        r_period_meas <= w_period_clip;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysref_align_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sysref_align_monitor
// Description : SYSREF alignment monitor in the pl_clk domain. Measures the
//               SYSREF edge-to-edge period, declares lock after LOCK_COUNT
//               consecutive matching periods, then emits a one-cycle aligned
//               sync pulse and a wrapping LMFC-style phase count. Period
//               errors and edge loss are counted for software debug.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   pl_clk       in   PL fabric clock (same as the SYSREF capture flop)
//   pl_resetn    in   asynchronous active-low reset
//   sysref_in    in   captured SYSREF level, synchronous to pl_clk
//   enable       in   monitor enable; low forces IDLE
//   err_clr      in   synchronous clear of err_cnt (wins over an error)
//   sysref_pulse out  one-cycle aligned SYSREF strobe while locked
//   locked       out  lock status
//   period_meas  out  last measured period (CNT_W bits)
//   lmfc_phase   out  phase count 0..EXP_PERIOD-1 (CNT_W bits)
//   err_cnt      out  saturating error count (ERR_W bits)
// ============================================================================
module sysref_align_monitor
  import sysref_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = c_default_exp_period,
  parameter int TOL        = c_default_tol,
  parameter int LOCK_COUNT = c_default_lock_count,
  parameter int ERR_W      = 16
) (
  input  logic             pl_clk,
  input  logic             pl_resetn,
  input  logic             sysref_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic             sysref_pulse,
  output logic             locked,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] lmfc_phase,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int               c_mc_w       = $clog2(LOCK_COUNT + 1);
  localparam logic [c_mc_w-1:0] c_lock_count = c_mc_w'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  c_phase_max  = CNT_W'(EXP_PERIOD - 1);

  sysref_state_t     r_state;
  logic [c_mc_w-1:0] r_match_cnt;
  logic              r_pulse;
  logic              r_locked;
  logic [CNT_W-1:0]  r_phase;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_run;
  logic              w_meas_en;
  logic              w_rise;
  logic              w_match;
  logic              w_timeout;
  logic              w_err;
  logic [c_mc_w-1:0] w_match_next;

  // Counter runs in every state but IDLE; gating with enable keeps it at 0
  // from the first IDLE cycle onward.
  assign w_run     = enable && (r_state != IDLE);
  assign w_meas_en = enable && ((r_state == MEASURE) || (r_state == LOCKED));

  sysref_edge_period #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL)
  ) u_edge_period (
    .pl_clk        (pl_clk),
    .pl_resetn     (pl_resetn),
    .i_run         (w_run),
    .i_meas_en     (w_meas_en),
    .i_sysref      (sysref_in),
    .o_rise        (w_rise),
    .o_match       (w_match),
    .o_timeout     (w_timeout),
    .o_period_meas (period_meas)
  );

  assign w_match_next = r_match_cnt + c_mc_w'(1);

  // An error is a mismatching period or a lost edge, only in the states
  // that are actually tracking the period.
  assign w_err = w_meas_en && ((w_rise && !w_match) || w_timeout);

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      r_state     <= IDLE;
      r_match_cnt <= '0;
      r_pulse     <= 1'b0;
      r_locked    <= 1'b0;
      r_phase     <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (!enable) begin
        r_state     <= IDLE;
        r_match_cnt <= '0;
        r_locked    <= 1'b0;
        r_phase     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= SEARCH;
          end

          SEARCH: begin
            if (w_rise) begin
              r_state <= MEASURE;
            end
          end

          MEASURE: begin
            if (w_rise) begin
              if (w_match) begin
                if (w_match_next == c_lock_count) begin
                  r_state     <= LOCKED;
                  r_locked    <= 1'b1;
                  r_pulse     <= 1'b1;
                  r_phase     <= '0;
                  r_match_cnt <= '0;
                end else begin
                  r_match_cnt <= w_match_next;
                end
              end else begin
                r_match_cnt <= '0;
              end
            end else if (w_timeout) begin
              r_match_cnt <= '0;
              r_state     <= SEARCH;
            end
          end

          LOCKED: begin
            r_phase <= (r_phase == c_phase_max) ? '0 : r_phase + CNT_W'(1);
            if (w_rise) begin
              if (w_match) begin
                r_pulse <= 1'b1;
                r_phase <= '0;
              end else begin
                r_locked    <= 1'b0;
                r_match_cnt <= '0;
                r_phase     <= '0;
                r_state     <= MEASURE;
              end
            end else if (w_timeout) begin
              r_locked    <= 1'b0;
              r_match_cnt <= '0;
              r_phase     <= '0;
              r_state     <= SEARCH;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear in the same cycle as an error wins.
  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign sysref_pulse = r_pulse;
  assign locked       = r_locked;
  assign lmfc_phase   = r_phase;
  assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/sysref_align_monitor.md
Name: sysref_align_monitor

Overview:
- Sits directly downstream of the PL SYSREF capture flop, in the pl_clk domain.
- Takes the captured SYSREF level, detects rising edges and measures the edge-to-edge period in pl_clk cycles.
- Declares lock after LOCK_COUNT consecutive periods that match EXP_PERIOD; while locked, emits a one-cycle aligned sync pulse and a wrapping LMFC-style phase count.
- Counts period errors and edge-loss events for software debug.

Parameters:
- CNT_W, 16, width of the period counter, period_meas and lmfc_phase.
- EXP_PERIOD, 64, expected SYSREF period in pl_clk cycles. Legal range: 2 .. 2**CNT_W-2.
- TOL, 0, allowed deviation (+/-) in cycles for a period to count as a match.
- LOCK_COUNT, 4, consecutive matching periods required to enter LOCKED.
- ERR_W, 16, width of err_cnt.

Ports:
- pl_clk  in  1  PL fabric clock, same clock as the SYSREF capture flop.
- pl_resetn  in  1  asynchronous active-low reset.
- sysref_in  in  1  captured SYSREF level, already synchronous to pl_clk.
- enable  in  1  monitor enable; low forces IDLE.
- err_clr  in  1  synchronous clear of err_cnt.
- sysref_pulse  out  1  one-cycle aligned SYSREF strobe, only when locked.
- locked  out  1  lock status.
- period_meas  out  CNT_W  last measured period.
- lmfc_phase  out  CNT_W  phase count 0..EXP_PERIOD-1.
- err_cnt  out  ERR_W  saturating error count.

Behaviour:
- Reset: all outputs 0, state IDLE, sysref_d=0, cnt=0, match_cnt=0.
- Edge detect:
  - sysref_d is sysref_in registered.
  - rise = sysref_in & ~sysref_d.
  - All outputs are registered, so any response appears 1 cycle after the cycle in which rise is true.
- cnt (runs in every state except IDLE):
  - cleared to 0 on rise; otherwise increments, saturating at all-ones.
  - Measured period P = cnt+1, sampled on rise. Example: rises at cycles 0 and 64 give P=64.
- Match: |P - EXP_PERIOD| <= TOL.
- Timeout: cnt reaches EXP_PERIOD+TOL with no rise.
- States:
  - IDLE: enable=0. locked=0, sysref_pulse=0, cnt and match_cnt held at 0. Goes to SEARCH when enable=1.
  - SEARCH: wait for the first rise. On rise: clear cnt, go to MEASURE. No period is measured here and timeout is ignored.
  - MEASURE:
    - On rise: period_meas<=P.
    - On match: match_cnt++. If the new value equals LOCK_COUNT, go to LOCKED, assert sysref_pulse, set lmfc_phase<=0.
    - On mismatch: match_cnt<=0, err_cnt++, stay in MEASURE.
    - On timeout: err_cnt++, match_cnt<=0, go to SEARCH.
  - LOCKED:
    - locked=1.
    - On matching rise: sysref_pulse=1, lmfc_phase<=0, period_meas<=P.
    - On mismatching rise: period_meas<=P, err_cnt++, locked<=0, match_cnt<=0, go to MEASURE, no pulse.
    - On timeout: err_cnt++, locked<=0, go to SEARCH.
- lmfc_phase:
  - Increments modulo EXP_PERIOD every cycle while locked; it is forced to 0 on the lock-entry or matching rise.
  - Holds 0 when not locked.
- enable falling in any state: next cycle state=IDLE, locked=0, match_cnt=0. period_meas and err_cnt are retained.
- err_cnt:
  - Saturates at all-ones.
  - err_clr clears it; if err_clr and an error occur in the same cycle, clear wins (result 0).
- sysref_pulse is never high for 2 consecutive cycles. A held-high sysref_in produces only one rise.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared package sysref_pkg holds:
  - state enum {IDLE, SEARCH, MEASURE, LOCKED} as a 2-bit encoding;
  - default constants for EXP_PERIOD, TOL and LOCK_COUNT, also used by the capture-side timing constraints and the software register map.
- One natural sub-module: sysref_edge_period, containing the edge detect, cnt, P calculation, match/timeout flags and period_meas.
- The FSM, lmfc_phase and err_cnt stay in the top level.

Test Plan:
- Lock acquisition: enable=1, 1-cycle SYSREF pulses every 64 cycles. Expected:
  - locked rises 1 cycle after the 5th rise (first rise plus 4 matching periods);
  - sysref_pulse coincides with lock entry and repeats every 64 cycles;
  - period_meas=64, err_cnt=0.
- Phase alignment: once locked, lmfc_phase reads 0 on the cycle sysref_pulse is high, then 1..63, then wraps to 0 exactly at the next pulse.
- Period error while locked: one period of 65 (TOL=0). Expected:
  - locked drops 1 cycle after that rise, no pulse, err_cnt=1, period_meas=65;
  - relock after 4 further matching periods.
- Edge loss: stop SYSREF while locked. After cnt reaches 64 with no rise: locked=0, state SEARCH, err_cnt+1. Restarting pulses relocks.
- Enable, clear and reset:
  - Deassert enable mid-MEASURE (match_cnt=2): next cycle IDLE, outputs 0, err_cnt retained.
  - Assert err_clr in the same cycle as a mismatch: err_cnt=0.
  - Drive pl_resetn low asynchronously: all outputs 0 immediately.
- Held level and saturation:
  - sysref_in held high for 200 cycles gives exactly one rise and no repeated pulse.
  - Forcing 2**ERR_W+3 errors leaves err_cnt saturated at all-ones.
